// File: rtl/sprite_anim_rom.sv
// Animated indexed-colour sprite source: frame ROM -> run-time RGB888 palette, 2-stage pipeline.
// The sprite image is a built-in constant pattern; the palette is loaded at run time through pal_we.
module sprite_anim_rom #(
    parameter int unsigned XBITS      = 6,
    parameter int unsigned YBITS      = 6,
    parameter int unsigned BPP        = 4,
    parameter int unsigned FBITS      = 2,
    parameter int unsigned ANIM_DIV   = 8,
    parameter int unsigned TRANSP_IDX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [XBITS-1:0] x,
    input  logic [YBITS-1:0] y,
    input  logic             frame_sync,
    input  logic             anim_en,
    input  logic             frame_set_we,
    input  logic [FBITS-1:0] frame_set,
    input  logic             pal_we,
    input  logic [BPP-1:0]   pal_idx,
    input  logic [23:0]      pal_data,
    output logic             pix_valid,
    output logic [23:0]      pix_rgb,
    output logic             pix_transp,
    output logic [FBITS-1:0] frame_num
);

    localparam int unsigned NPAL  = 2 ** BPP;
    localparam int unsigned DBITS = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [23:0]      r_pal [NPAL];
    logic             r_v1;
    logic [BPP-1:0]   r_idx;
    logic             r_pix_valid;
    logic [23:0]      r_pix_rgb;
    logic             r_pix_transp;
    logic [FBITS-1:0] r_frame;
    logic [DBITS-1:0] r_div;

    logic [BPP-1:0]   w_rom_idx;
    logic [23:0]      w_pal_rd;

    // Sprite image contents as a function of the {frame, y, x} address.
    function automatic logic [BPP-1:0] rom_word(input logic [FBITS-1:0] f,
                                                input logic [YBITS-1:0] yy,
                                                input logic [XBITS-1:0] xx);
        logic [31:0] s;
        s = 32'(xx) + 32'd3 * 32'(yy) + 32'd5 * 32'(f);
        return s[BPP-1:0];
    endfunction

    assign w_rom_idx = rom_word(r_frame, y, x);
    assign w_pal_rd  = r_pal[r_idx];

    always_ff @(posedge clk) begin
        if (pal_we) begin
            r_pal[pal_idx] <= pal_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1         <= 1'b0;
            r_idx        <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_rgb    <= '0;
            r_pix_transp <= 1'b0;
            r_frame      <= '0;
            r_div        <= '0;
        end else begin
            r_v1 <= req;
            if (req) begin
                r_idx <= w_rom_idx;
            end

            r_pix_valid <= r_v1;
            if (r_v1) begin
                r_pix_rgb    <= w_pal_rd;
                r_pix_transp <= (r_idx == BPP'(TRANSP_IDX));
            end

            // A forced frame load wins over an animation step in the same cycle.
            if (frame_set_we) begin
                r_frame <= frame_set;
                r_div   <= '0;
            end else if (anim_en && frame_sync) begin
                if (r_div == DBITS'(ANIM_DIV - 1)) begin
                    r_div   <= '0;
                    r_frame <= r_frame + 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pix_rgb    = r_pix_rgb;
    assign pix_transp = r_pix_transp;
    assign frame_num  = r_frame;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Scoreboard bench for sprite_anim_rom: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_sprite_anim_rom;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        frame_sync;
    logic        anim_en;
    logic        frame_set_we;
    logic [1:0]  frame_set;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_data;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic        pix_transp;
    logic [1:0]  frame_num;

    int          total = 0;
    int          bad   = 0;
    logic [24:0] sb [$];
    logic [23:0] m_pal [16];
    int          m_frame = 0;
    logic        pv;

    sprite_anim_rom #(
        .XBITS(6), .YBITS(6), .BPP(4), .FBITS(2), .ANIM_DIV(8), .TRANSP_IDX(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .x(x), .y(y),
        .frame_sync(frame_sync), .anim_en(anim_en),
        .frame_set_we(frame_set_we), .frame_set(frame_set),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_transp(pix_transp),
        .frame_num(frame_num)
    );

    always #5 clk = ~clk;

    // Sprite image: index = (x + 3y + 5*frame) mod 16.
    function automatic logic [3:0] img_idx(input int f, input int yy, input int xx);
        int s;
        s = (xx + 3 * yy + 5 * f) % 16;
        return 4'(s);
    endfunction

    function automatic logic [23:0] pal_init(input int i);
        return {8'(i * 17), 8'(160 + i), 8'(200 - i * 9)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n === 1'b1 && pix_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pixel_unexpected: got rgb=%06h transp=%0b expected no pixel", pix_rgb, pix_transp);
            end else begin
                e = sb.pop_front();
                chk("pixel", {7'd0, pix_rgb, pix_transp}, {7'd0, e});
            end
        end
    end

    task automatic step(input logic rq, input int xx, input int yy,
                        input logic pw, input int pi, input logic [23:0] pd,
                        input logic fw, input int fv, output logic pvo);
        logic [3:0] ix;
        @(posedge clk);
        #1;
        pvo          = pix_valid;
        req          = rq;
        x            = 6'(xx);
        y            = 6'(yy);
        pal_we       = pw;
        pal_idx      = 4'(pi);
        pal_data     = pd;
        frame_set_we = fw;
        frame_set    = 2'(fv);
        frame_sync   = 1'b0;
        if (pw) m_pal[pi] = pd;
        if (rq) begin
            ix = img_idx(m_frame, yy, xx);
            sb.push_back({m_pal[ix], ix == 4'd0});
        end
        if (fw) m_frame = fv;
    endtask

    task automatic idle(input int n);
        logic d;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 24'h0, 1'b0, 0, d);
    endtask

    task automatic pulse(input logic fw, input int fv);
        @(posedge clk);
        #1;
        frame_sync   = 1'b1;
        frame_set_we = fw;
        frame_set    = 2'(fv);
        @(posedge clk);
        #1;
        frame_sync   = 1'b0;
        frame_set_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; x = '0; y = '0; frame_sync = 1'b0; anim_en = 1'b0;
        frame_set_we = 1'b0; frame_set = '0; pal_we = 1'b0; pal_idx = '0; pal_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  32'(pix_valid),  32'd0);
        chk("rst_rgb",    32'(pix_rgb),    32'd0);
        chk("rst_transp", 32'(pix_transp), 32'd0);
        chk("rst_frame",  32'(frame_num),  32'd0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b0, 0, 0, 1'b1, i, pal_init(i), 1'b0, 0, pv);
        idle(1);

        // First request at (0,0): valid appears exactly two clocks later, index 0 is transparent.
        step(1'b1, 0, 0, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        chk("lat_issue", 32'(pv), 32'd0);
        step(1'b1, 0, 0, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        chk("lat_clk1", 32'(pv), 32'd0);
        step(1'b1, 0, 0, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        chk("lat_clk2", 32'(pv), 32'd1);
        idle(3);

        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++)
                step(1'b1, xx, yy, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        idle(3);
        chk("raster_drain", 32'(sb.size()), 32'd0);

        anim_en = 1'b1;
        for (int p = 1; p <= 32; p++) begin
            pulse(1'b0, 0);
            chk("anim_step", 32'(frame_num), 32'((p / 8) % 4));
        end
        repeat (3) pulse(1'b0, 0);
        chk("anim_div3", 32'(frame_num), 32'd0);
        anim_en = 1'b0;
        repeat (10) pulse(1'b0, 0);
        chk("anim_frozen", 32'(frame_num), 32'd0);
        anim_en = 1'b1;
        repeat (4) pulse(1'b0, 0);
        chk("anim_div7", 32'(frame_num), 32'd0);
        pulse(1'b1, 2);
        chk("set_priority", 32'(frame_num), 32'd2);
        repeat (7) pulse(1'b0, 0);
        chk("set_div_clear", 32'(frame_num), 32'd2);
        pulse(1'b0, 0);
        chk("set_then_step", 32'(frame_num), 32'd3);
        anim_en = 1'b0;
        m_frame = 3;

        // Request issued with a frame load still uses frame 3; the next one uses frame 0.
        step(1'b1, 1, 0, 1'b0, 0, 24'h0, 1'b1, 0, pv);
        step(1'b1, 1, 0, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        // Palette write lands while the previous idx-5 pixel is in S2: that pixel keeps the old colour.
        step(1'b1, 5, 0, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        step(1'b1, 5, 0, 1'b1, 5, 24'h00ff00, 1'b0, 0, pv);
        step(1'b1, 5, 0, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        idle(3);
        chk("pal_drain", 32'(sb.size()), 32'd0);
        chk("frame_after_set", 32'(frame_num), 32'd0);

        step(1'b0, 0, 0, 1'b0, 0, 24'h0, 1'b1, 3, pv);
        for (int i = 0; i < 40; i++) step(1'b1, i, 7, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk("midrst_valid", 32'(pix_valid), 32'd0);
        chk("midrst_frame", 32'(frame_num), 32'd0);
        sb.delete();
        m_frame = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        step(1'b1, 3, 2, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        chk("relat_issue", 32'(pv), 32'd0);
        step(1'b1, 3, 2, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        chk("relat_clk1", 32'(pv), 32'd0);
        step(1'b1, 3, 2, 1'b0, 0, 24'h0, 1'b0, 0, pv);
        chk("relat_clk2", 32'(pv), 32'd1);
        idle(3);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
